// File: rtl/pll_frac_div_sdm.sv
// Fractional-N clock divider with a first-order or MASH 1-1 sigma-delta
// modulator choosing the integer divisor of each output period.
// Optional build macro: PLL_FRAC_DIV_DITHER_EN adds a 1-bit LFSR dither to
// the first accumulator input each period.
module pll_frac_div_sdm #(
  parameter int INT_WIDTH  = 6,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [INT_WIDTH-1:0]  int_div,
  input  logic [FRAC_WIDTH-1:0] frac_div,
  input  logic                  cfg_load,
  output logic                  clkout,
  output logic                  period_done,
  output logic [INT_WIDTH+1:0]  cur_div,
  output logic                  busy
);

  localparam int NW = INT_WIDTH + 2;
  localparam int FW = FRAC_WIDTH;
  localparam logic signed [NW-1:0] MIN_DIV = NW'(2);

  // Divisors below 2 cannot produce a high and a low phase, so clamp.
  function automatic logic [NW-1:0] clamp_div(input logic signed [NW-1:0] v);
    return (v < MIN_DIV) ? $unsigned(MIN_DIV) : $unsigned(v);
  endfunction

  // ceil(n/2) without needing an extra carry bit.
  function automatic logic [NW-1:0] half_up(input logic [NW-1:0] n);
    return (n >> 1) + NW'(n[0]);
  endfunction

  logic [NW-1:0]        cnt;
  logic [INT_WIDTH-1:0] sh_int;
  logic [FW-1:0]        sh_frac;
  logic                 sh_mode;
  logic                 pending;
  logic [FW-1:0]        acc1;
  logic [FW-1:0]        acc2;
  logic                 c2_prev;

  logic                 period_end;
  logic                 load_now;
  logic                 start;
  logic                 mode_chg;
  logic [INT_WIDTH-1:0] eff_int;
  logic [FW-1:0]        eff_frac;
  logic                 eff_mode;
  logic [FW-1:0]        a1;
  logic [FW-1:0]        a2;
  logic                 cp;
  logic [FW:0]          sum1;
  logic [FW:0]          sum2;
  logic                 c1;
  logic                 c2;
  logic signed [NW-1:0] n_raw;
  logic [NW-1:0]        n_new;
  logic [NW-1:0]        cnt_inc;
  logic                 dither;

`ifdef PLL_FRAC_DIV_DITHER_EN
  logic [14:0] lfsr;

  // x^15 + x^14 + 1 LFSR, stepped once per period alongside the accumulators.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst)        lfsr <= 15'h1;
    else if (start) lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
  end

  assign dither = lfsr[0];
`else
  assign dither = 1'b0;
`endif

  // Effective configuration, modulator step and next divisor.
  always_comb begin
    period_end = busy && (cnt == cur_div - NW'(1));
    load_now   = (pending || cfg_load) && (!busy || period_end);
    start      = en && (!busy || period_end);
    eff_int    = load_now ? int_div  : sh_int;
    eff_frac   = load_now ? frac_div : sh_frac;
    eff_mode   = load_now ? mode     : sh_mode;
    // A modulator change restarts from a clean state so the new noise
    // shaping is not polluted by residue of the old one.
    mode_chg   = load_now && (mode != sh_mode);
    a1         = mode_chg ? '0   : acc1;
    a2         = mode_chg ? '0   : acc2;
    cp         = mode_chg ? 1'b0 : c2_prev;
    sum1       = {1'b0, a1} + {1'b0, eff_frac} + {{FW{1'b0}}, dither};
    c1         = sum1[FW];
    sum2       = {1'b0, a2} + {1'b0, sum1[FW-1:0]};
    c2         = sum2[FW];
    if (eff_mode)
      n_raw = $signed({2'b00, eff_int}) + $signed({{(NW-1){1'b0}}, c1})
            + $signed({{(NW-1){1'b0}}, c2}) - $signed({{(NW-1){1'b0}}, cp});
    else
      n_raw = $signed({2'b00, eff_int}) + $signed({{(NW-1){1'b0}}, c1});
    n_new   = clamp_div(n_raw);
    cnt_inc = cnt + NW'(1);
  end

  // Shadow configuration, period counter, modulator state and outputs.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sh_int      <= '0;
      sh_frac     <= '0;
      sh_mode     <= 1'b0;
      pending     <= 1'b0;
      acc1        <= '0;
      acc2        <= '0;
      c2_prev     <= 1'b0;
      cnt         <= '0;
      cur_div     <= '0;
      clkout      <= 1'b0;
      period_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (load_now) begin
        sh_int  <= int_div;
        sh_frac <= frac_div;
        sh_mode <= mode;
      end
      if (load_now)      pending <= 1'b0;
      else if (cfg_load) pending <= 1'b1;

      if (start) begin
        // New period begins on this edge with no idle gap.
        busy        <= 1'b1;
        cnt         <= '0;
        cur_div     <= n_new;
        clkout      <= 1'b1;
        period_done <= 1'b0;
        acc1        <= sum1[FW-1:0];
        if (eff_mode) begin
          acc2    <= sum2[FW-1:0];
          c2_prev <= c2;
        end else begin
          acc2    <= a2;
          c2_prev <= cp;
        end
      end else begin
        // Modulator state holds, except for a clear on a mode change.
        acc1    <= a1;
        acc2    <= a2;
        c2_prev <= cp;
        if (period_end) begin
          busy        <= 1'b0;
          cnt         <= '0;
          clkout      <= 1'b0;
          period_done <= 1'b0;
        end else if (busy) begin
          cnt         <= cnt_inc;
          clkout      <= (cnt_inc < half_up(cur_div));
          period_done <= (cnt_inc == cur_div - NW'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_frac_div_sdm.sv
// Randomized and directed bench for pll_frac_div_sdm; period lengths,
// divisors and duty are compared against an arithmetic modulator model.
module tb_pll_frac_div_sdm;

  localparam int IW  = 6;
  localparam int FW  = 8;
  localparam int MOD = 1 << FW;

  logic          clkin = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [IW-1:0] int_div;
  logic [FW-1:0] frac_div;
  logic          cfg_load;
  logic          clkout;
  logic          period_done;
  logic [IW+1:0] cur_div;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // model state
  int m_acc1, m_acc2, m_c2p, m_mode, m_int, m_frac;

  pll_frac_div_sdm #(.INT_WIDTH(IW), .FRAC_WIDTH(FW)) dut (
    .clkin(clkin), .rst(rst), .en(en), .mode(mode), .int_div(int_div),
    .frac_div(frac_div), .cfg_load(cfg_load), .clkout(clkout),
    .period_done(period_done), .cur_div(cur_div), .busy(busy)
  );

  always #5 clkin = ~clkin;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_acc1 = 0; m_acc2 = 0; m_c2p = 0; m_mode = 0; m_int = 0; m_frac = 0;
  endfunction

  function automatic void model_load(input int i, input int f, input int m);
    if (m != m_mode) begin
      m_acc1 = 0; m_acc2 = 0; m_c2p = 0;
    end
    m_int = i; m_frac = f; m_mode = m;
  endfunction

  // Divisor of the next period from the ratio int + frac/2^FW.
  function automatic int model_next();
    int s1, s2, c1, c2, n;
    s1 = m_acc1 + m_frac;
    c1 = s1 / MOD;
    m_acc1 = s1 % MOD;
    if (m_mode == 1) begin
      s2 = m_acc2 + m_acc1;
      c2 = s2 / MOD;
      m_acc2 = s2 % MOD;
      n = m_int + c1 + c2 - m_c2p;
      m_c2p = c2;
    end else begin
      n = m_int + c1;
    end
    return (n < 2) ? 2 : n;
  endfunction

  task automatic do_reset();
    @(negedge clkin);
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
    @(negedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge: loads config and enables in the same edge.
  task automatic start_cfg(input int i, input int f, input int m);
    int_div = IW'(i); frac_div = FW'(f); mode = m[0];
    cfg_load = 1'b1; en = 1'b1;
    model_load(i, f, m);
    @(posedge clkin);
    #1 cfg_load = 1'b0;
  endtask

  // Counts cycles from the next negedge up to and including period_done.
  task automatic measure_period(output int len, output int hi, output int nseen,
                                output int busylow);
    bit done;
    len = 0; hi = 0; nseen = -1; busylow = 0; done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clkin);
      len++;
      if (clkout) hi++;
      if (!busy) busylow++;
      if (k == 0) nseen = int'(cur_div);
      if (period_done) done = 1;
    end
    if (!done) check_eq("period_timeout", int'(period_done), 1);
  endtask

  task automatic run_periods(input int count, input string tag, output int tot,
                             output int nmin, output int nmax);
    int len, hi, nseen, bl, exp;
    tot = 0; nmin = 1 << 30; nmax = -1;
    for (int p = 0; p < count; p++) begin
      exp = model_next();
      measure_period(len, hi, nseen, bl);
      check_eq({tag, "_len"}, len, exp);
      check_eq({tag, "_div"}, nseen, exp);
      check_eq({tag, "_high"}, hi, (exp + 1) / 2);
      check_eq({tag, "_busy"}, bl, 0);
      tot += len;
      if (nseen < nmin) nmin = nseen;
      if (nseen > nmax) nmax = nseen;
    end
  endtask

  initial begin
    int tot, mn, mx, len, hi, nseen, bl, cnt_hi, cnt_pd;
    rst = 1'b1; en = 1'b0; mode = 1'b0; int_div = '0; frac_div = '0; cfg_load = 1'b0;
    model_reset();
    repeat (2) @(negedge clkin);
    check_eq("rst_clkout", int'(clkout), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_pd", int'(period_done), 0);
    check_eq("rst_div", int'(cur_div), 0);
    rst = 1'b0;
    repeat (3) @(negedge clkin);
    check_eq("idle_busy", int'(busy), 0);

    // integer ratio
    start_cfg(4, 0, 0);
    run_periods(8, "int4", tot, mn, mx);
    check_eq("int4_total", tot, 32);

    // half fraction, first order
    do_reset();
    start_cfg(4, 128, 0);
    run_periods(16, "half", tot, mn, mx);
    check_eq("half_total", tot, 72);

    // MASH 1-1
    do_reset();
    start_cfg(8, 64, 1);
    run_periods(256, "mash", tot, mn, mx);
    check_eq("mash_total", tot, 2112);
    check_eq("mash_min_ok", int'(mn >= 7), 1);
    check_eq("mash_max_ok", int'(mx <= 10), 1);

    // random configurations, then a reload coinciding with a period end
    for (int r = 0; r < 6; r++) begin
      int ni, nf, nm;
      do_reset();
      start_cfg($urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 1));
      run_periods(20, "rnd", tot, mn, mx);
      ni = $urandom_range(0, 12); nf = $urandom_range(0, 255); nm = $urandom_range(0, 1);
      int_div = IW'(ni); frac_div = FW'(nf); mode = nm[0]; cfg_load = 1'b1;
      model_load(ni, nf, nm);
      @(posedge clkin);
      #1 cfg_load = 1'b0;
      run_periods(20, "rndld", tot, mn, mx);
    end

    // shadowing: int_div change without cfg_load has no effect
    do_reset();
    start_cfg(4, 0, 0);
    run_periods(2, "shd", tot, mn, mx);
    int_div = 6;
    run_periods(2, "shd_nold", tot, mn, mx);
    @(negedge clkin);                  // count 0 of an N=4 period
    cfg_load = 1'b1;
    @(posedge clkin);
    #1 cfg_load = 1'b0;
    measure_period(len, hi, nseen, bl);
    check_eq("pend_rest_len", len, 3);
    check_eq("pend_rest_div", nseen, 4);
    measure_period(len, hi, nseen, bl);
    check_eq("pend_new_len", len, 6);
    check_eq("pend_new_div", nseen, 6);
    check_eq("pend_new_high", hi, 3);
    // load on the period-end edge applies immediately
    int_div = 5; cfg_load = 1'b1;
    @(posedge clkin);
    #1 cfg_load = 1'b0;
    measure_period(len, hi, nseen, bl);
    check_eq("coin_len", len, 5);
    check_eq("coin_div", nseen, 5);
    check_eq("coin_high", hi, 3);

    // en dropped at count 1 of an N=5 period
    @(negedge clkin);                  // count 0
    @(negedge clkin);                  // count 1
    en = 1'b0;
    measure_period(len, hi, nseen, bl);
    check_eq("stop_len", len, 3);
    check_eq("stop_high", hi, 1);
    check_eq("stop_busy_in", bl, 0);
    @(negedge clkin);
    check_eq("stop_busy", int'(busy), 0);
    check_eq("stop_clkout", int'(clkout), 0);
    cnt_hi = 0; cnt_pd = 0;
    repeat (10) begin
      @(negedge clkin);
      if (clkout) cnt_hi++;
      if (period_done) cnt_pd++;
    end
    check_eq("stop_idle_high", cnt_hi, 0);
    check_eq("stop_idle_pd", cnt_pd, 0);

    // reset mid-period, restart with int_div=1
    start_cfg(4, 0, 0);
    @(negedge clkin);
    @(negedge clkin);
    rst = 1'b1;
    #1;
    check_eq("arst_clkout", int'(clkout), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_div", int'(cur_div), 0);
    check_eq("arst_pd", int'(period_done), 0);
    cnt_pd = 0;
    repeat (3) begin
      @(negedge clkin);
      if (period_done) cnt_pd++;
    end
    check_eq("arst_no_pd", cnt_pd, 0);
    rst = 1'b0; int_div = 1; cfg_load = 1'b1;
    @(posedge clkin);
    #1 cfg_load = 1'b0;
    measure_period(len, hi, nseen, bl);
    check_eq("clamp_len", len, 2);
    check_eq("clamp_div", nseen, 2);
    check_eq("clamp_high", hi, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
